// File: rtl/shift_add_multiplier_4_bit_pkg.sv
// Shared definitions for the 4-bit shift-and-add multiplier.
package shift_add_multiplier_4_bit_pkg;

    localparam int unsigned OPERAND_W  = 4;
    localparam int unsigned PRODUCT_W  = 2 * OPERAND_W;
    localparam int unsigned ITER_COUNT = 4;

    // Last value of the 2-bit iteration counter before leaving RUN
    localparam logic [1:0] LAST_ITER = 2'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_4_bit_adder.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    // Ripple the carry through four full-adder stages
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/shift_add_multiplier_4_bit.sv
// Sequential 4x4 unsigned multiplier: one shift-and-add iteration per RUN cycle.
module shift_add_multiplier_4_bit
    import shift_add_multiplier_4_bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [PRODUCT_W-1:0] product
);

    state_t               state;
    logic [1:0]           count;
    logic [OPERAND_W-1:0] mcand;
    logic [OPERAND_W-1:0] mplier;
    logic [OPERAND_W-1:0] acc_hi;

    logic [OPERAND_W-1:0] addend;
    logic [OPERAND_W-1:0] sum;
    logic                 cout;
    logic                 carry;
    logic [OPERAND_W-1:0] next_acc_hi;
    logic [OPERAND_W-1:0] next_mplier;

    ripple_carry_adder_4_bit u_adder (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // One iteration: conditional add of mcand, then shift {carry,sum,mplier} right by one
    always_comb begin
        addend      = mplier[0] ? mcand : '0;
        carry       = mplier[0] ? cout : 1'b0;
        // bit 8 of the 9-bit shift result is always zero, so the shift is written out per field
        next_acc_hi = {carry, sum[OPERAND_W-1:1]};
        next_mplier = {sum[0], mplier[OPERAND_W-1:1]};
    end

    // Control FSM with registered busy/done/product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc_hi  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc_hi <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= next_acc_hi;
                    mplier <= next_mplier;
                    count  <= count + 2'd1;
                    if (count == LAST_ITER) begin
                        // last iteration lands in product on the same edge
                        product <= {next_acc_hi, next_mplier};
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier_4_bit.sv
// Directed testbench for shift_add_multiplier_4_bit.
module tb_shift_add_multiplier_4_bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int unsigned vectors;
    int unsigned miscompares;

    shift_add_multiplier_4_bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the done pulse after the start edge has just been sampled
    task automatic wait_done(input string tag, input logic [7:0] exp, input bit full);
        int unsigned lat;
        int unsigned busy_cycles;
        bit          got;
        lat = 0;
        busy_cycles = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cycles++;
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_product"}, 32'(product), 32'(exp));
        if (full) begin
            check({tag, "_latency"}, lat, 32'd4);
            check({tag, "_busy_cycles"}, busy_cycles, 32'd5);
            @(posedge clk); #1;
            check({tag, "_done_single"}, 32'(done), 32'd0);
            check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_mult(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                           input logic [7:0] exp, input bit full);
        @(negedge clk);
        a = ta;
        b = tb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(tag, exp, full);
    endtask

    initial begin
        int unsigned pulses;
        int          last_idx;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic products
        do_mult("m15x15", 4'd15, 4'd15, 8'hE1, 1);
        do_mult("m13x11", 4'd13, 4'd11, 8'h8F, 1);
        do_mult("m0x9",   4'd0,  4'd9,  8'h00, 1);

        // start re-asserted during RUN is ignored
        @(negedge clk);
        a = 4'd1;
        b = 4'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        a = 4'd15;
        b = 4'd15;
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                check("ignore_product", 32'(product), 32'h07);
            end
        end
        check("ignore_pulses", pulses, 32'd1);

        // Reset mid-operation aborts, then a fresh start on the first edge after release
        @(negedge clk);
        a = 4'd12;
        b = 4'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_pulse", pulses, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_rst_accept", 32'(busy), 32'd1);
        wait_done("m3x5", 8'h0F, 1);

        // start held high: one operation every 6 cycles, product stable between pulses
        @(negedge clk);
        a = 4'd6;
        b = 4'd7;
        start = 1'b1;
        pulses = 0;
        last_idx = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                check("held_product", 32'(product), 32'h2A);
                if (last_idx >= 0) check("held_period", 32'(i - last_idx), 32'd6);
                last_idx = i;
            end else if (pulses == 0) begin
                check("held_stable_pre", 32'(product), 32'h0F);
            end else begin
                check("held_stable", 32'(product), 32'h2A);
            end
        end
        check("held_pulses", pulses, 32'd3);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) @(posedge clk);
        #1;

        // Exhaustive sweep against a*b
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_mult("sweep", 4'(i), 4'(j), 8'(i * j), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
